// File: rtl/pc_trace_checker.sv
// PC trace checker: watches a core's PC and memory bus against
// programmed trap and checkpoint tables and reports a pass/fail verdict.
module pc_trace_checker #(
    parameter int XLEN  = 32,
    parameter int NCHK  = 8,
    parameter int NTRAP = 4,
    parameter int TMO_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    input  logic            mem_write,
    input  logic [XLEN-1:0] data_adr,
    input  logic [XLEN-1:0] write_data,
    input  logic [XLEN-1:0] read_data,
    input  logic            arm,
    input  logic            cfg_we,
    input  logic            cfg_trap,
    input  logic [4:0]      cfg_idx,
    input  logic [1:0]      cfg_kind,
    input  logic [XLEN-1:0] cfg_pc,
    input  logic [XLEN-1:0] cfg_adr,
    input  logic [XLEN-1:0] cfg_data,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [2:0]      fail_code,
    output logic [XLEN-1:0] fail_pc,
    output logic [7:0]      hits
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL
    } state_t;

    localparam logic [1:0] K_OFF = 2'b00;
    localparam logic [1:0] K_LD  = 2'b10;
    localparam logic [1:0] K_FIN = 2'b11;

    state_t state_q, state_d;

    logic [1:0]      ck_kind [NCHK];
    logic [XLEN-1:0] ck_pc   [NCHK];
    logic [XLEN-1:0] ck_adr  [NCHK];
    logic [XLEN-1:0] ck_data [NCHK];
    logic            trap_vld[NTRAP];
    logic [XLEN-1:0] trap_pc [NTRAP];

    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [2:0]       fc_d;
    logic [XLEN-1:0]  fpc_d;
    logic [7:0]       hits_d;

    logic             trap_hit;
    logic             ck_hit;
    logic             ck_ok;
    logic [1:0]       sel_kind;
    logic [XLEN-1:0]  sel_adr;
    logic [XLEN-1:0]  sel_data;

    // Table writes, locked out while a run is in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NCHK; i++) begin
                ck_kind[i] <= K_OFF;
                ck_pc[i]   <= '0;
                ck_adr[i]  <= '0;
                ck_data[i] <= '0;
            end
            for (int i = 0; i < NTRAP; i++) begin
                trap_vld[i] <= 1'b0;
                trap_pc[i]  <= '0;
            end
        end else if (cfg_we && state_q != ST_RUN) begin
            if (cfg_trap) begin
                for (int i = 0; i < NTRAP; i++) begin
                    if (cfg_idx == 5'(i)) begin
                        trap_vld[i] <= (cfg_kind != K_OFF);
                        trap_pc[i]  <= cfg_pc;
                    end
                end
            end else begin
                for (int i = 0; i < NCHK; i++) begin
                    if (cfg_idx == 5'(i)) begin
                        ck_kind[i] <= cfg_kind;
                        ck_pc[i]   <= cfg_pc;
                        ck_adr[i]  <= cfg_adr;
                        ck_data[i] <= cfg_data;
                    end
                end
            end
        end
    end

    // Table lookup: any trap match, lowest-index enabled checkpoint match
    always_comb begin
        trap_hit = 1'b0;
        for (int i = 0; i < NTRAP; i++) begin
            if (trap_vld[i] && trap_pc[i] == pc) begin
                trap_hit = 1'b1;
            end
        end
        ck_hit   = 1'b0;
        sel_kind = K_OFF;
        sel_adr  = '0;
        sel_data = '0;
        for (int i = NCHK - 1; i >= 0; i--) begin
            if (ck_kind[i] != K_OFF && ck_pc[i] == pc) begin
                ck_hit   = 1'b1;
                sel_kind = ck_kind[i];
                sel_adr  = ck_adr[i];
                sel_data = ck_data[i];
            end
        end
        if (sel_kind == K_LD) begin
            ck_ok = (read_data == sel_data);
        end else begin
            ck_ok = mem_write
                  && (data_adr == sel_adr)
                  && (write_data == sel_data);
        end
    end

    assign tmo_inc = tmo_q + TMO_W'(1);

    // Next state and verdict: trap beats checkpoint beats timeout
    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        fc_d    = fail_code;
        fpc_d   = fail_pc;
        hits_d  = hits;
        unique case (state_q)
            ST_RUN: begin
                tmo_d = tmo_inc;
                if (trap_hit) begin
                    state_d = ST_FAIL;
                    fc_d    = 3'd1;
                    fpc_d   = pc;
                end else if (ck_hit) begin
                    if (!ck_ok) begin
                        state_d = ST_FAIL;
                        fc_d    = (sel_kind == K_LD) ? 3'd3 : 3'd2;
                        fpc_d   = pc;
                    end else begin
                        if (hits != 8'hff) begin
                            hits_d = hits + 8'd1;
                        end
                        if (sel_kind == K_FIN) begin
                            state_d = ST_PASS;
                            fc_d    = 3'd0;
                        end
                    end
                end else if (&tmo_inc) begin
                    state_d = ST_FAIL;
                    fc_d    = 3'd4;
                    fpc_d   = pc;
                end
            end
            default: begin
                if (arm) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                    fc_d    = 3'd0;
                    fpc_d   = '0;
                    hits_d  = 8'd0;
                end
            end
        endcase
    end

    // State and verdict registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            fail_code <= 3'd0;
            fail_pc   <= '0;
            hits      <= 8'd0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            fail_code <= fc_d;
            fail_pc   <= fpc_d;
            hits      <= hits_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_PASS) || (state_q == ST_FAIL);
    assign pass = (state_q == ST_PASS);

endmodule

// File: tb/tb_pc_trace_checker.sv
// Directed bench for pc_trace_checker: table-driven trace vectors
// plus hand-written timeout, config-lockout and reset sequences.
module tb_pc_trace_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic        mem_write;
    logic [31:0] data_adr;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        arm;
    logic        cfg_we;
    logic        cfg_trap;
    logic [4:0]  cfg_idx;
    logic [1:0]  cfg_kind;
    logic [31:0] cfg_pc;
    logic [31:0] cfg_adr;
    logic [31:0] cfg_data;
    logic        busy;
    logic        done;
    logic        pass;
    logic [2:0]  fail_code;
    logic [31:0] fail_pc;
    logic [7:0]  hits;

    int checks = 0;
    int errors = 0;

    pc_trace_checker #(
        .XLEN (32),
        .NCHK (8),
        .NTRAP(4),
        .TMO_W(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .mem_write (mem_write),
        .data_adr  (data_adr),
        .write_data(write_data),
        .read_data (read_data),
        .arm       (arm),
        .cfg_we    (cfg_we),
        .cfg_trap  (cfg_trap),
        .cfg_idx   (cfg_idx),
        .cfg_kind  (cfg_kind),
        .cfg_pc    (cfg_pc),
        .cfg_adr   (cfg_adr),
        .cfg_data  (cfg_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_code (fail_code),
        .fail_pc   (fail_pc),
        .hits      (hits)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        mw;
        logic [31:0] adr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        busy;
        logic        done;
        logic        pass;
        logic [2:0]  fc;
        logic [31:0] fpc;
        logic [7:0]  hits;
    } vec_t;

    vec_t q36[$];
    vec_t q37[$];
    vec_t q38[$];
    vec_t qld[$];

    function automatic vec_t mk(
        input logic [31:0] p, input logic m, input logic [31:0] a,
        input logic [31:0] w, input logic [31:0] r,
        input logic b, input logic d, input logic ps,
        input logic [2:0] f, input logic [31:0] fp, input logic [7:0] h);
        vec_t v;
        v.pc = p; v.mw = m; v.adr = a; v.wd = w; v.rd = r;
        v.busy = b; v.done = d; v.pass = ps;
        v.fc = f; v.fpc = fp; v.hits = h;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t v);
        chk({nm, " busy"}, 32'(busy), 32'(v.busy));
        chk({nm, " done"}, 32'(done), 32'(v.done));
        chk({nm, " pass"}, 32'(pass), 32'(v.pass));
        chk({nm, " fail_code"}, 32'(fail_code), 32'(v.fc));
        chk({nm, " fail_pc"}, fail_pc, v.fpc);
        chk({nm, " hits"}, 32'(hits), 32'(v.hits));
    endtask

    task automatic drive(input logic [31:0] p, input logic m,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] r);
        pc = p; mem_write = m; data_adr = a; write_data = w; read_data = r;
    endtask

    task automatic run_tbl(input string nm, input vec_t q[$]);
        foreach (q[i]) begin
            drive(q[i].pc, q[i].mw, q[i].adr, q[i].wd, q[i].rd);
            @(posedge clk);
            #1;
            chk_all($sformatf("%s[%0d]", nm, i), q[i]);
        end
    endtask

    task automatic set_cfg(input logic t, input logic [4:0] i,
                           input logic [1:0] k, input logic [31:0] p,
                           input logic [31:0] a, input logic [31:0] d);
        cfg_trap = t; cfg_idx = i; cfg_kind = k;
        cfg_pc = p; cfg_adr = a; cfg_data = d;
    endtask

    task automatic cfg_write(input logic t, input logic [4:0] i,
                             input logic [1:0] k, input logic [31:0] p,
                             input logic [31:0] a, input logic [31:0] d);
        set_cfg(t, i, k, p, a, d);
        cfg_we = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(posedge clk);
        #1;
        arm = 1'b0;
    endtask

    initial begin
        vec_t z;
        q36.push_back(mk(32'h00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        q36.push_back(mk(32'h2c, 1, 32'h2004, 32'h14, 0, 1, 0, 0, 0, 0, 1));
        q36.push_back(mk(32'h30, 1, 32'h2008, 32'h3803, 0, 1, 0, 0, 0, 0, 2));
        q36.push_back(mk(32'h34, 0, 0, 0, 32'h14, 1, 0, 0, 0, 0, 3));
        q36.push_back(mk(32'h38, 0, 0, 0, 0, 1, 0, 0, 0, 0, 3));
        q36.push_back(mk(32'h68, 1, 32'h200c, 32'h18, 0, 0, 1, 1, 0, 0, 4));
        q36.push_back(mk(32'h10, 0, 0, 0, 0, 0, 1, 1, 0, 0, 4));

        q37.push_back(mk(32'h2c, 1, 32'h2004, 32'h15, 0, 0, 1, 0, 2, 32'h2c, 0));
        q37.push_back(mk(32'h34, 0, 0, 0, 32'h14, 0, 1, 0, 2, 32'h2c, 0));

        q38.push_back(mk(32'h38, 0, 0, 0, 32'h77, 1, 0, 0, 0, 0, 1));
        q38.push_back(mk(32'h3c, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        q38.push_back(mk(32'h40, 0, 0, 0, 0, 0, 1, 0, 1, 32'h40, 1));

        qld.push_back(mk(32'h34, 0, 0, 0, 32'h13, 0, 1, 0, 3, 32'h34, 0));

        reset = 1'b1;
        arm = 1'b0;
        cfg_we = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_all("reset", z);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        cfg_write(1, 0, 2'b01, 32'h10, 0, 0);
        cfg_write(1, 1, 2'b01, 32'h40, 0, 0);
        cfg_write(0, 0, 2'b01, 32'h2c, 32'h2004, 32'h14);
        cfg_write(0, 1, 2'b01, 32'h30, 32'h2008, 32'h3803);
        cfg_write(0, 2, 2'b10, 32'h34, 0, 32'h14);
        cfg_write(0, 3, 2'b11, 32'h68, 32'h200c, 32'h18);
        cfg_write(0, 8, 2'b10, 32'h2c, 0, 32'hdead);
        cfg_write(1, 4, 2'b01, 32'h2c, 0, 0);

        do_arm();
        chk("arm busy", 32'(busy), 32'd1);
        run_tbl("pass_trace", q36);

        do_arm();
        run_tbl("store_fail", q37);

        set_cfg(0, 4, 2'b10, 32'h38, 0, 32'h77);
        cfg_we = 1'b1;
        do_arm();
        cfg_we = 1'b0;
        run_tbl("cfg_arm_trap", q38);

        do_arm();
        run_tbl("load_fail", qld);

        cfg_write(0, 5, 2'b10, 32'h34, 0, 32'h99);
        do_arm();
        drive(32'h34, 0, 0, 0, 32'h14);
        @(posedge clk);
        #1;
        chk("dup busy", 32'(busy), 32'd1);
        chk("dup hits", 32'(hits), 32'd1);
        drive(0, 0, 0, 0, 0);
        cfg_write(1, 0, 2'b00, 32'h10, 0, 0);
        chk("cfg_in_run busy", 32'(busy), 32'd1);
        drive(32'h10, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("cfg_in_run fail_code", 32'(fail_code), 32'd1);
        chk("cfg_in_run fail_pc", fail_pc, 32'h10);

        do_arm();
        drive(0, 0, 0, 0, 0);
        for (int i = 1; i <= 14; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tmo busy c%0d", i), 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        chk_all("timeout", mk(0, 0, 0, 0, 0, 0, 1, 0, 4, 0, 0));

        do_arm();
        drive(32'h2c, 1, 32'h2004, 32'h14, 0);
        @(posedge clk);
        #1;
        chk("pre_reset hits", 32'(hits), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", z);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h10, 0, 0, 0, 0);
        do_arm();
        @(posedge clk);
        #1;
        chk("post_reset trap busy", 32'(busy), 32'd1);
        drive(32'h2c, 1, 32'h2004, 32'h15, 0);
        @(posedge clk);
        #1;
        chk("post_reset ck busy", 32'(busy), 32'd1);
        drive(32'h68, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("post_reset run", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_trace_checker.md
PC_TRACE_CHECKER -- requirements
Module: pc_trace_checker

Interface
REQ-001 Parameter XLEN, default 32, width of pc/address/data buses.
REQ-002 Parameter NCHK, default 8, number of checkpoint table entries (2..32).
REQ-003 Parameter NTRAP, default 4, number of fail-trap PC entries (1..16).
REQ-004 Parameter TMO_W, default 16, timeout counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 pc  in  XLEN  program counter of the observed core.
REQ-008 mem_write  in  1  observed store strobe.
REQ-009 data_adr  in  XLEN  observed data address.
REQ-010 write_data  in  XLEN  observed store data.
REQ-011 read_data  in  XLEN  observed load data.
REQ-012 arm  in  1  start-check pulse.
REQ-013 cfg_we  in  1  config write strobe; cfg_trap selects trap table (1) or checkpoint table (0).
REQ-014 cfg_idx  in  5  entry index; cfg_kind in 2; cfg_pc, cfg_adr, cfg_data in XLEN each.
REQ-015 busy, done, pass  out  1 each; fail_code  out  3; fail_pc  out  XLEN; hits  out  8.

Function
REQ-016 Checkpoint kind: 00 disabled; 01 store check; 10 load check; 11 final store check.
REQ-017 Store check passes iff mem_write==1, data_adr==exp_adr, write_data==exp_data (all bits).
REQ-018 Load check passes iff read_data==exp_data; data_adr and mem_write ignored.
REQ-019 FSM states IDLE, RUN, PASS, FAIL; reset state IDLE.
REQ-020 IDLE/PASS/FAIL: arm=1 -> RUN next edge; clears hits, timeout counter, fail_code, fail_pc.
REQ-021 RUN: every edge, pc compared to all valid trap entries and enabled checkpoint entries.
REQ-022 Priority per cycle: trap hit > checkpoint compare > timeout.
REQ-023 Trap hit -> FAIL, fail_code=1, fail_pc=pc.
REQ-024 Checkpoint match, check fails -> FAIL, fail_code=2 (store/final) or 3 (load), fail_pc=pc.
REQ-025 Multiple checkpoint matches same pc: lowest index only evaluated.
REQ-026 Passing check: hits+1, saturating at 255; kind 11 pass -> PASS, fail_code=0.
REQ-027 Timeout counter increments each RUN cycle; at all-ones with no pass/fail that cycle -> FAIL, fail_code=4, fail_pc=pc.
REQ-028 Checkpoint match resets nothing; timeout is total run cycles, not per-checkpoint.
REQ-029 Outputs registered: verdict visible one cycle after the sampling edge.
REQ-030 busy=1 only in RUN; done=1 in PASS or FAIL; pass=1 only in PASS; PASS/FAIL sticky until arm or reset.
REQ-031 cfg_we honoured only outside RUN; ignored in RUN; cfg_idx >= table depth ignored.
REQ-032 cfg_we and arm same edge outside RUN: write takes effect, then RUN uses new entry.
REQ-033 Trap entry written with cfg_kind!=00 is valid; 00 invalidates it.

Reset
REQ-034 reset=1 asynchronously: state IDLE, busy/done/pass=0, fail_code=0, fail_pc=0, hits=0, counter=0.
REQ-035 reset clears all table kinds to 00/invalid; reset mid-RUN aborts with no verdict.

Verification
REQ-036 Traps at 0x10,0x40; ckpts 0x2c store(0x2004,0x14), 0x30 store(0x2008,0x3803), 0x34 load 0x14, 0x68 final(0x200c,0x18); matching trace -> pass=1, hits=4.
REQ-037 Same table, write_data=0x15 at pc 0x2c -> fail_code=2, fail_pc=0x2c, hits=0.
REQ-038 pc reaches 0x40 -> fail_code=1, fail_pc=0x40 next cycle, done=1.
REQ-039 TMO_W=4, pc stuck at 0x0 after arm -> fail_code=4 after 15 RUN cycles, busy=0.
REQ-040 Entries 2 and 5 both pc 0x34, entry 2 load 0x14 correct, entry 5 wrong -> no fail.
REQ-041 Assert reset mid-RUN then cfg_we in RUN ignored check: all outputs 0, table invalid, arm -> RUN with no checks.
